// File: rtl/led_scan_driver.sv
// Multiplexed LED-cube scan engine: shifts one BCM bit plane per pass into parallel serial
// chains, latches it, then drives the row for a binary-weighted window scaled by brightness.
module led_scan_driver #(
    parameter int unsigned NUM_CHANNELS     = 12,
    parameter int unsigned NUM_ROWS         = 16,
    parameter int unsigned BITS_PER_CHANNEL = 16,
    parameter int unsigned BCM_BITS         = 4,
    parameter int unsigned SCLK_HALF        = 2,
    parameter int unsigned UNIT_CYCLES      = 16,
    parameter int unsigned BLANK_CYCLES     = 8
) (
    input  logic                                                     clk,
    input  logic                                                     reset,
    input  logic                                                     enable,
    input  logic [7:0]                                               brightness,
    output logic [$clog2(NUM_ROWS)+$clog2(BITS_PER_CHANNEL)-1:0]     rd_addr,
    input  logic [NUM_CHANNELS*BCM_BITS-1:0]                         rd_data,
    output logic                                                     serial_clk,
    output logic                                                     latch_enable,
    output logic                                                     output_enable_n,
    output logic [NUM_CHANNELS-1:0]                                  serial_data_out,
    output logic [NUM_ROWS-1:0]                                      row_select_n,
    output logic                                                     frame_done,
    output logic                                                     busy
);

    localparam int unsigned RowW   = $clog2(NUM_ROWS);
    localparam int unsigned ColW   = $clog2(BITS_PER_CHANNEL);
    localparam int unsigned PlaneW = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
    localparam int unsigned PhW    = $clog2(2 * SCLK_HALF);
    localparam int unsigned MaxWin = UNIT_CYCLES << (BCM_BITS - 1);
    localparam int unsigned CntMax = (MaxWin > BLANK_CYCLES) ? MaxWin : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [PhW-1:0]    PhLoad    = PhW'(1);
    localparam logic [PhW-1:0]    PhHigh    = PhW'(SCLK_HALF);
    localparam logic [PhW-1:0]    PhLast    = PhW'(2 * SCLK_HALF - 1);
    localparam logic [ColW-1:0]   ColLast   = ColW'(BITS_PER_CHANNEL - 1);
    localparam logic [RowW-1:0]   RowLast   = RowW'(NUM_ROWS - 1);
    localparam logic [PlaneW-1:0] PlaneLast = PlaneW'(BCM_BITS - 1);
    localparam logic [CntW-1:0]   BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0]   LatchLast = CntW'(1);

    typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

    state_e                          state_q, state_d;
    logic [RowW-1:0]                 row_q, row_d;
    logic [PlaneW-1:0]               plane_q, plane_d;
    logic [ColW-1:0]                 col_q, col_d;
    logic [PhW-1:0]                  ph_q, ph_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [CntW-1:0]                 on_q, on_d;
    logic [NUM_CHANNELS-1:0]         sdo_q, sdo_d;
    logic                            frame_done_q, frame_done_d;

    logic [NUM_CHANNELS-1:0][BCM_BITS-1:0] chan_vals;
    logic [NUM_CHANNELS-1:0]               fresh;
    logic [CntW-1:0]                       win;
    logic [CntW-1:0]                       on_next;

    assign chan_vals = rd_data;
    assign win       = CntW'(UNIT_CYCLES) << plane_q;
    // On-time = floor(W * brightness / 256)
    assign on_next   = CntW'(({8'd0, win} * {{CntW{1'b0}}, brightness}) >> 8);

    always_comb begin
        fresh = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            fresh[k] = chan_vals[k][plane_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            ph_q         <= '0;
            cnt_q        <= '0;
            on_q         <= '0;
            sdo_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            ph_q         <= ph_d;
            cnt_q        <= cnt_d;
            on_q         <= on_d;
            sdo_q        <= sdo_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        col_d        = col_q;
        ph_d         = ph_q;
        cnt_d        = cnt_q;
        on_d         = on_q;
        sdo_d        = sdo_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StShift;
                    row_d   = '0;
                    plane_d = '0;
                    col_d   = ColLast;
                    ph_d    = '0;
                end
            end
            StShift: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == PhLoad) begin
                    sdo_d = fresh;
                end
                if (ph_q == PhLast) begin
                    ph_d = '0;
                    if (col_q == '0) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_q - 1'b1;
                    end
                end
            end
            StBlank: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BlankLast) begin
                    state_d = StLatch;
                    cnt_d   = '0;
                end
            end
            StLatch: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LatchLast) begin
                    state_d = StDisplay;
                    cnt_d   = '0;
                    on_d    = on_next;
                end
            end
            StDisplay: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == win - 1'b1) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    col_d   = ColLast;
                    if (plane_q == PlaneLast) begin
                        plane_d = '0;
                        if (row_q == RowLast) begin
                            // Frame end is the only point where enable is honoured
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            if (!enable) begin
                                state_d = StIdle;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        plane_d = plane_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        serial_clk      = (state_q == StShift) && (ph_q >= PhHigh);
        latch_enable    = (state_q == StLatch);
        output_enable_n = !((state_q == StDisplay) && (cnt_q < on_q));
        row_select_n    = '1;
        if (state_q == StDisplay) begin
            row_select_n[row_q] = 1'b0;
        end
        // Fresh plane bits appear in the second low-phase clk, then the register holds them
        serial_data_out = ((state_q == StShift) && (ph_q == PhLoad)) ? fresh : sdo_q;
        rd_addr         = {row_q, col_q};
        frame_done      = frame_done_q;
        busy            = (state_q != StIdle);
    end

endmodule

// File: tb/tb_led_scan_driver.sv
// Randomized scoreboard bench for led_scan_driver: expected shift bits, latch/blank timing,
// display windows and frame pulses are queued per frame and popped by a negedge monitor.
module tb_led_scan_driver;

    localparam int NC = 2, NR = 2, BPC = 4, BCM = 2, SH = 2, UNIT = 4, BLANK = 2;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            reset, enable;
    logic [7:0]      brightness;
    logic [AW-1:0]   rd_addr;
    logic [NC*BCM-1:0] rd_data;
    logic            serial_clk, latch_enable, output_enable_n, frame_done, busy;
    logic [NC-1:0]   serial_data_out;
    logic [NR-1:0]   row_select_n;

    led_scan_driver #(
        .NUM_CHANNELS(NC), .NUM_ROWS(NR), .BITS_PER_CHANNEL(BPC), .BCM_BITS(BCM),
        .SCLK_HALF(SH), .UNIT_CYCLES(UNIT), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .brightness(brightness),
        .rd_addr(rd_addr), .rd_data(rd_data), .serial_clk(serial_clk),
        .latch_enable(latch_enable), .output_enable_n(output_enable_n),
        .serial_data_out(serial_data_out), .row_select_n(row_select_n),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [8];
    always @(posedge clk) rd_data <= mem[rd_addr];

    typedef struct packed {logic [1:0] sdo; logic [2:0] addr;} shift_t;
    typedef struct packed {logic [1:0] rsel; logic [7:0] w; logic [7:0] on;} disp_t;
    shift_t shift_q[$];
    disp_t  disp_q[$];
    int     latch_q[$];
    int     frame_q[$];

    int total = 0, bad = 0;
    bit mon_off = 1'b0;
    int fd_seen = 0;
    int oe_leak = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event not expected or timed out", name);
    endtask

    // Reference: scan order, per-plane bit extraction and window arithmetic straight from the rules
    task automatic push_frame(input int b);
        shift_t se;
        disp_t  de;
        for (int r = 0; r < NR; r++) begin
            for (int p = 0; p < BCM; p++) begin
                for (int c = BPC - 1; c >= 0; c--) begin
                    se.addr = 3'(r * BPC + c);
                    for (int k = 0; k < NC; k++) se.sdo[k] = mem[r * BPC + c][k * BCM + p];
                    shift_q.push_back(se);
                end
                latch_q.push_back(BLANK);
                de.w    = 8'(UNIT << p);
                de.on   = 8'((int'(de.w) * b) / 256);
                de.rsel = 2'(~(1 << r));
                disp_q.push_back(de);
            end
        end
        frame_q.push_back(NR * BCM);
    endtask

    // Monitor state
    int cyc = 0, rise_cnt = 0, last_rise = 0, sck_age = 0, win_cnt = 0;
    bit prev_sck = 0, prev_fd = 0, in_latch = 0, in_disp = 0, d_off_seen = 0, d_gap = 0;
    int latch_len = 0, blank_seen = 0, d_len = 0, d_on = 0;
    logic [1:0] d_rsel;
    logic [AW-1:0] addr_h1 = '0, addr_h2 = '0;

    always @(negedge clk) begin
        shift_t se;
        disp_t  de;
        int     eb, ew;
        cyc++;
        if (mon_off || reset) begin
            prev_sck = 0; prev_fd = 0; rise_cnt = 0; in_latch = 0; in_disp = 0;
            win_cnt = 0; sck_age = 0;
        end else begin
            if (serial_clk && !prev_sck) begin
                if (rise_cnt > 0) check("rise_spacing", cyc - last_rise, 2 * SH);
                if (shift_q.size() == 0) fail_now("unexpected_rise");
                else begin
                    se = shift_q.pop_front();
                    check("sdo_at_rise", serial_data_out, se.sdo);
                    check("rd_addr_col", addr_h2, se.addr);
                end
                rise_cnt++;
                last_rise = cyc;
            end
            sck_age = serial_clk ? 0 : sck_age + 1;

            if (latch_enable) begin
                if (!in_latch) begin
                    in_latch   = 1;
                    latch_len  = 0;
                    blank_seen = sck_age - 1;
                    check("rises_per_plane", rise_cnt, BPC);
                end
                latch_len++;
            end else if (in_latch) begin
                in_latch = 0;
                rise_cnt = 0;
                if (latch_q.size() == 0) fail_now("unexpected_latch");
                else begin
                    eb = latch_q.pop_front();
                    check("latch_len", latch_len, 2);
                    check("blank_len", blank_seen, eb);
                end
            end

            if (row_select_n != 2'b11) begin
                if (!in_disp) begin
                    in_disp = 1; d_rsel = row_select_n; d_len = 0; d_on = 0;
                    d_off_seen = 0; d_gap = 0;
                end
                if (row_select_n != d_rsel) d_gap = 1;
                d_len++;
                if (!output_enable_n) begin
                    d_on++;
                    if (d_off_seen) d_gap = 1;
                end else d_off_seen = 1;
            end else begin
                if (!output_enable_n) oe_leak++;
                if (in_disp) begin
                    in_disp = 0;
                    win_cnt++;
                    if (disp_q.size() == 0) fail_now("unexpected_display");
                    else begin
                        de = disp_q.pop_front();
                        check("row_select", d_rsel, de.rsel);
                        check("window_len", d_len, de.w);
                        check("oe_on_clks", d_on, de.on);
                        check("oe_contiguous", d_gap, 0);
                    end
                end
            end

            if (frame_done) begin
                check("fd_pulse_1clk", prev_fd, 0);
                if (frame_q.size() == 0) fail_now("unexpected_frame_done");
                else begin
                    ew = frame_q.pop_front();
                    check("windows_per_frame", win_cnt, ew);
                end
                win_cnt = 0;
                fd_seen++;
            end
            prev_sck = serial_clk;
            prev_fd  = frame_done;
        end
        addr_h2 = addr_h1;
        addr_h1 = rd_addr;
    end

    task automatic run(input int nframes);
        int n;
        int fd0;
        fd0 = fd_seen;
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk); #1 check("busy_after_enable", busy, 1);
        if (nframes == 1) begin
            // Lands in row 0, plane 1
            repeat (28) @(posedge clk);
            #1 enable = 1'b0;
        end else begin
            n = 0;
            while (fd_seen == fd0 && n < 2000) begin @(posedge clk); n++; end
            if (fd_seen == fd0) fail_now("frame_done_timeout");
            #1 enable = 1'b0;
        end
        n = 0;
        while (busy && n < 2000) begin @(posedge clk); #1; n++; end
        if (busy) fail_now("busy_timeout");
        repeat (10) @(posedge clk);
        #1;
        check("stays_idle", busy, 0);
        check("frames_seen", fd_seen - fd0, nframes);
        check("idle_rows_off", row_select_n, 2'b11);
    endtask

    task automatic rand_mem();
        for (int a = 0; a < 8; a++) mem[a] = 4'($urandom);
    endtask

    initial begin
        int b;
        reset = 1'b1; enable = 1'b0; brightness = 8'd0;
        for (int a = 0; a < 8; a++) mem[a] = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe_n", output_enable_n, 1);
        check("rst_row_sel", row_select_n, 2'b11);
        check("rst_latch", latch_enable, 0);
        check("rst_sclk", serial_clk, 0);
        check("rst_busy", busy, 0);
        check("rst_fd", frame_done, 0);
        check("rst_sdo", serial_data_out, 0);
        check("rst_rd_addr", rd_addr, 0);
        reset = 1'b0;

        for (int a = 0; a < 8; a++) mem[a] = 4'b0011;
        brightness = 8'd255; push_frame(255); run(1);

        for (int a = 0; a < 8; a++) mem[a] = {2'($urandom), 2'd2};
        brightness = 8'd128; push_frame(128); run(1);

        rand_mem(); brightness = 8'd0; push_frame(0); run(1);

        for (int i = 0; i < 3; i++) begin
            rand_mem();
            b = int'($urandom_range(0, 255));
            brightness = 8'(b); push_frame(b); run(1);
        end

        rand_mem();
        b = int'($urandom_range(1, 255));
        brightness = 8'(b); push_frame(b); push_frame(b); run(2);

        check("shift_q_drained", shift_q.size(), 0);
        check("disp_q_drained", disp_q.size(), 0);
        check("latch_q_drained", latch_q.size(), 0);
        check("frame_q_drained", frame_q.size(), 0);
        check("oe_leak", oe_leak, 0);

        // Reset mid-SHIFT
        mon_off = 1'b1;
        @(posedge clk); #1 enable = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("busy_mid_shift", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_busy", busy, 0);
        check("mrst_sclk", serial_clk, 0);
        check("mrst_sdo", serial_data_out, 0);
        check("mrst_rd_addr", rd_addr, 0);
        check("mrst_oe_n", output_enable_n, 1);
        check("mrst_row_sel", row_select_n, 2'b11);
        check("mrst_latch", latch_enable, 0);
        enable = 1'b0;
        reset  = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
